imem_loader: RTL and testbench

Boot-time program loader driving the instruction memory's synchronous write port (`RegWrite`, `WriteReg`, `WriteData`) from a byte stream. It accepts a length header, assembles little-endian 32-bit words, writes them to consecutive word addresses starting at 0, and holds the CPU off until loading completes. It sits between the host/debug byte link and the instruction memory. The CPU fetch path uses the memory's combinational read port and is not touched by this block.

---
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream link from the host/debug side into the program loader.
// master drives bytes, slave (the loader) returns byte_ready.
interface imem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length byte + little-endian words -> imem write port; holds CPU until done.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int WORDS = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  imem_loader_if.slave      bs,
  output logic              RegWrite,
  output logic [31:0]       WriteReg,
  output logic [31:0]       WriteData,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int IW = $clog2(WORDS) + 1;

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, DONE, ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t          state;
  logic [7:0]      len;
  logic [IW-1:0]   idx;
  logic [1:0]      bcnt;
  logic [23:0]     partial;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  logic take;
  assign take = bs.byte_valid && bs.byte_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      len           <= '0;
      idx           <= '0;
      bcnt          <= '0;
      partial       <= '0;
      bs.byte_ready <= 1'b0;
      RegWrite      <= 1'b0;
      WriteReg      <= '0;
      WriteData     <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= LEN;
            bs.byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end

        LEN: begin
          if (take) begin
            if (bs.byte_in == 8'd0 || {24'd0, bs.byte_in} > 32'(WORDS)) begin
              state         <= ERR;
              bs.byte_ready <= 1'b0;
              error         <= 1'b1;
            end else begin
              len   <= bs.byte_in;
              idx   <= '0;
              bcnt  <= '0;
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (take) begin
            // Bytes arrive LSB first, so shifting right leaves byte k at [8k+7:8k].
            partial <= {bs.byte_in, partial[23:8]};
            bcnt    <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= csum ^ bs.byte_in;
`endif
            if (bcnt == 2'd3) begin
              state         <= WRITE;
              bs.byte_ready <= 1'b0;
              RegWrite      <= 1'b1;
              WriteReg      <= 32'(idx);
              WriteData     <= {bs.byte_in, partial};
            end
          end
        end

        WRITE: begin
          if (32'(idx) + 32'd1 == 32'(len)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state         <= CHECK;
            bs.byte_ready <= 1'b1;
`else
            state         <= DONE;
            done          <= 1'b1;
            cpu_hold      <= 1'b0;
`endif
          end else begin
            // Only advance when another word follows, so idx stays below WORDS.
            idx           <= idx + 1'b1;
            state         <= DATA;
            bs.byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (take) begin
            bs.byte_ready <= 1'b0;
            if (bs.byte_in == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          if (start) begin
            state         <= LEN;
            done          <= 1'b0;
            cpu_hold      <= 1'b1;
            bs.byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end

        ERR: begin
          if (start) begin
            state         <= LEN;
            error         <= 1'b0;
            bs.byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end

        default: begin
          state         <= IDLE;
          bs.byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, loads, length errors, async abort, restart.
module tb_imem_loader;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        RegWrite;
  logic [31:0] WriteReg;
  logic [31:0] WriteData;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader_if bs ();

  imem_loader #(.WORDS(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .bs        (bs),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory-side view: one record per write strobe; the stream must be stalled then.
  always @(negedge clock) begin
    if (RegWrite === 1'b1) begin
      wa.push_back(WriteReg);
      wd.push_back(WriteData);
      chk("ready_low_in_write", {31'd0, bs.byte_ready}, 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bs.byte_in    = b;
    bs.byte_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = bs.byte_ready;
      tick();
    end
    chk("send_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    bs.byte_valid = 1'b0;
    tick(n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_flag(input bit want_done);
    for (int k = 0; k < 20; k++) begin
      if ((want_done && done === 1'b1) || (!want_done && error === 1'b1)) break;
      tick();
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int t0;
    int base;

    reset_n       = 1'b0;
    start         = 1'b0;
    bs.byte_valid = 1'b0;
    bs.byte_in    = 8'h00;
    tick(3);
    chk("reset_cpu_hold",   {31'd0, cpu_hold},      32'd1);
    chk("reset_byte_ready", {31'd0, bs.byte_ready}, 32'd0);
    chk("reset_done",       {31'd0, done},          32'd0);
    chk("reset_error",      {31'd0, error},         32'd0);
    chk("reset_regwrite",   {31'd0, RegWrite},      32'd0);
    chk("reset_writereg",   WriteReg,               32'd0);
    chk("reset_writedata",  WriteData,              32'd0);

    reset_n       = 1'b1;
    bs.byte_valid = 1'b1;
    bs.byte_in    = 8'h05;
    tick(3);
    chk("idle_ready_low", {31'd0, bs.byte_ready}, 32'd0);
    chk("idle_cpu_hold",  {31'd0, cpu_hold},      32'd1);
    bs.byte_valid = 1'b0;

    // Two-word load, valid held continuously (including through WRITE cycles)
    pulse_start();
    t0 = cyc;
    chk("len_ready", {31'd0, bs.byte_ready}, 32'd1);
    send(8'h02);
    send(8'hB3); send(8'h00); send(8'hA2); send(8'h00);
    send(8'h33); send(8'h01); send(8'h12); send(8'h40);
    chk("hold_before_done", {31'd0, cpu_hold}, 32'd1);
    chk("done_before_end",  {31'd0, done},     32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    // XOR of the eight data bytes is 0x71.
    send(8'h71);
`endif
    bs.byte_valid = 1'b0;
    wait_flag(1'b1);
    chk("load1_done", {31'd0, done}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("load1_cycles", cyc - t0, 32'd12);
`else
    chk("load1_cycles", cyc - t0, 32'd11);
`endif
    chk("load1_cpu_hold", {31'd0, cpu_hold},      32'd0);
    chk("load1_error",    {31'd0, error},         32'd0);
    chk("load1_ready",    {31'd0, bs.byte_ready}, 32'd0);
    chk("load1_nwrites",  wa.size(),              32'd2);
    chk("load1_addr0", qget(wa, 0), 32'd0);
    chk("load1_data0", qget(wd, 0), 32'h00A2_00B3);
    chk("load1_addr1", qget(wa, 1), 32'd1);
    chk("load1_data1", qget(wd, 1), 32'h4012_0133);

    // Restart from DONE; one-word load with gaps and a stray start mid-DATA
    pulse_start();
    chk("restart_done",  {31'd0, done},          32'd0);
    chk("restart_hold",  {31'd0, cpu_hold},      32'd1);
    chk("restart_ready", {31'd0, bs.byte_ready}, 32'd1);
    base = wa.size();
    send(8'h01);
    idle(2);
    send(8'h78);
    idle(1);
    send(8'h56);
    bs.byte_valid = 1'b0;
    pulse_start();
    chk("midstart_ready", {31'd0, bs.byte_ready}, 32'd1);
    chk("midstart_error", {31'd0, error},         32'd0);
    send(8'h34);
    idle(3);
    send(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h08);
`endif
    bs.byte_valid = 1'b0;
    wait_flag(1'b1);
    chk("load2_done",    {31'd0, done}, 32'd1);
    chk("load2_nwrites", wa.size() - base, 32'd1);
    chk("load2_addr",    qget(wa, base), 32'd0);
    chk("load2_data",    qget(wd, base), 32'h1234_5678);

    // Length 0 -> ERR
    pulse_start();
    base = wa.size();
    send(8'h00);
    bs.byte_valid = 1'b0;
    tick();
    chk("len0_error", {31'd0, error},         32'd1);
    chk("len0_hold",  {31'd0, cpu_hold},      32'd1);
    chk("len0_ready", {31'd0, bs.byte_ready}, 32'd0);
    chk("len0_done",  {31'd0, done},          32'd0);

    // Recover, then length WORDS+1 -> ERR
    pulse_start();
    chk("err_recover_error", {31'd0, error},         32'd0);
    chk("err_recover_ready", {31'd0, bs.byte_ready}, 32'd1);
    send(8'd33);
    bs.byte_valid = 1'b0;
    tick();
    chk("len33_error", {31'd0, error},    32'd1);
    chk("len33_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("lenerr_nwrites", wa.size() - base, 32'd0);

    // Asynchronous reset after two data bytes: partial word must be dropped
    pulse_start();
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    bs.byte_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("arst_ready",     {31'd0, bs.byte_ready}, 32'd0);
    chk("arst_hold",      {31'd0, cpu_hold},      32'd1);
    chk("arst_error",     {31'd0, error},         32'd0);
    chk("arst_writedata", WriteData,              32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(6);
    chk("arst_nwrites", wa.size() - base, 32'd0);
    chk("arst_idle_ready", {31'd0, bs.byte_ready}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: ERR, words stay written, CPU stays held
    pulse_start();
    base = wa.size();
    send(8'h02);
    send(8'hB3); send(8'h00); send(8'hA2); send(8'h00);
    send(8'h33); send(8'h01); send(8'h12); send(8'h40);
    send(8'h78);
    bs.byte_valid = 1'b0;
    wait_flag(1'b0);
    chk("csum_bad_error", {31'd0, error},    32'd1);
    chk("csum_bad_done",  {31'd0, done},     32'd0);
    chk("csum_bad_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("csum_bad_nwr",   wa.size() - base,  32'd2);
    chk("csum_bad_data0", qget(wd, base),     32'h00A2_00B3);
    chk("csum_bad_data1", qget(wd, base + 1), 32'h4012_0133);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
